mem_arbiter: RTL and testbench

- Sequenced arbiter sharing the single RAM port between the instruction fetch path and the data (load/store) path of the pipelined datapath.
- Sits between the datapath's imem/dmem request signals (or their caches) and the RAM model.
- Grants one requester at a time and drives RAM address, data and enables for the granted requester.
- Returns per-requester wait/load responses.
- Data has priority, with a bounded-starvation guarantee for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/diaosi_types_pkg.sv | 10 +
 rtl/arb_starve_cnt.sv | 31 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM model's handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Types local to the memory arbitration logic.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE_ARB   = 2'd0,
    IGRANT_ARB = 2'd1,
    DGRANT_ARB = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data completions that overtook a pending instruction fetch.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [3:0] MaxCnt = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != MaxCnt))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins
// unless instruction fetch has been overtaken STARVE_MAX times in a row.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  word_t       iaddr,
  output logic        iwait,
  output word_t       iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        dwait,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  arb_state_t state_q, state_d;
  logic       err_q, err_d;
  ramstate_t  rs;
  logic       dreq, at_max, i_done, cnt_inc, cnt_clr;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc_i   (cnt_inc),
    .clr_i   (cnt_clr),
    .at_max_o(at_max)
  );

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    i_done   = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE_ARB: begin
        if (dreq && !(iREN && at_max)) state_d = DGRANT_ARB;
        else if (iREN)                 state_d = IGRANT_ARB;
      end
      IGRANT_ARB: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        // A withdrawn request ends the grant even if the RAM answers this cycle.
        if (!iREN) begin
          state_d = IDLE_ARB;
        end else if (rs == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          i_done  = 1'b1;
          state_d = IDLE_ARB;
        end
      end
      DGRANT_ARB: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE_ARB;
        end else if (rs == ACCESS) begin
          dwait   = 1'b0;
          dload   = dWEN ? '0 : ramload;
          cnt_inc = iREN;
          state_d = IDLE_ARB;
        end
      end
      default: state_d = IDLE_ARB;
    endcase
  end

  assign cnt_clr = i_done | ((state_q == IDLE_ARB) && !iREN);
  assign err_d   = err_q | ((state_q != IDLE_ARB) && (rs == ERROR));
  assign ram_err = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE_ARB;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, starvation bound, writes, errors, withdrawal, reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int d_done, i_seen, cyc;

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = RS_FREE;
    #12;
    chk("rst_ramREN", {31'd0, ramREN}, 0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", {31'd0, iwait}, 1);
    chk("rst_dwait", {31'd0, dwait}, 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ram_err", {31'd0, ram_err}, 0);
    nRST = 1'b1;

    // Test 1: instruction fetch, ACCESS on second grant cycle
    tick();
    iREN = 1; iaddr = 32'h0000_0040; settle();
    chk("t1_idle_ren", {31'd0, ramREN}, 0);
    chk("t1_idle_iwait", {31'd0, iwait}, 1);
    tick(); settle();
    chk("t1_g1_ren", {31'd0, ramREN}, 1);
    chk("t1_g1_addr", ramaddr, 32'h40);
    chk("t1_g1_iwait", {31'd0, iwait}, 1);
    tick();
    ramstate = RS_ACCESS; ramload = 32'h2001_0005; settle();
    chk("t1_g2_iwait", {31'd0, iwait}, 0);
    chk("t1_g2_iload", iload, 32'h2001_0005);
    tick();
    ramstate = RS_FREE; settle();
    chk("t1_c3_idle_ren", {31'd0, ramREN}, 0);
    chk("t1_c3_iwait", {31'd0, iwait}, 1);
    chk("t1_c3_iload", iload, 0);
    iREN = 0;

    // Test 2: simultaneous requests, data wins, then instruction
    tick();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; settle();
    tick(); settle();
    chk("t2_d_addr", ramaddr, 32'h100);
    chk("t2_d_ren", {31'd0, ramREN}, 1);
    chk("t2_d_wen", {31'd0, ramWEN}, 0);
    chk("t2_d_iwait", {31'd0, iwait}, 1);
    ramstate = RS_ACCESS; ramload = 32'h0000_1234; settle();
    chk("t2_d_dwait", {31'd0, dwait}, 0);
    chk("t2_d_dload", dload, 32'h1234);
    chk("t2_d_iwait2", {31'd0, iwait}, 1);
    dREN = 0;
    tick();
    ramstate = RS_FREE; settle();
    chk("t2_turn_ren", {31'd0, ramREN}, 0);
    tick(); settle();
    chk("t2_i_ren", {31'd0, ramREN}, 1);
    chk("t2_i_addr", ramaddr, 32'h44);
    ramstate = RS_ACCESS; ramload = 32'h0000_00AA; settle();
    chk("t2_i_iwait", {31'd0, iwait}, 0);
    chk("t2_i_iload", iload, 32'hAA);
    iREN = 0;
    tick();
    ramstate = RS_FREE; settle();

    // Test 3: starvation bound with zero-wait RAM
    dWEN = 1; daddr = 32'h300; dstore = 32'h1111_2222;
    iREN = 1; iaddr = 32'h80; ramstate = RS_ACCESS;
    d_done = 0; i_seen = 0; cyc = 0;
    while (!i_seen && cyc < 40) begin
      tick(); settle();
      cyc++;
      if (ramWEN && !dwait) d_done++;
      if (ramREN && ramaddr == 32'h80 && !iwait) i_seen = 1;
    end
    chk("t3_i_reached", i_seen, 1);
    chk("t3_d_completions", d_done, 4);
    tick(); settle();
    chk("t3_turn_wen", {31'd0, ramWEN}, 0);
    chk("t3_turn_ren", {31'd0, ramREN}, 0);
    tick(); settle();
    chk("t3_dwin_wen", {31'd0, ramWEN}, 1);
    chk("t3_dwin_iwait", {31'd0, iwait}, 1);
    chk("t3_dwin_dwait", {31'd0, dwait}, 0);
    dWEN = 0; iREN = 0;
    tick();
    ramstate = RS_FREE; settle();
    tick(); settle();

    // Test 4: write with dREN also high
    dWEN = 1; dREN = 1; dstore = 32'hDEAD_BEEF; daddr = 32'h200; ramload = 32'h5555_5555;
    tick(); settle();
    chk("t4_wen", {31'd0, ramWEN}, 1);
    chk("t4_ren", {31'd0, ramREN}, 0);
    chk("t4_store", ramstore, 32'hDEAD_BEEF);
    chk("t4_addr", ramaddr, 32'h200);
    chk("t4_dwait_busy", {31'd0, dwait}, 1);
    ramstate = RS_ACCESS; settle();
    chk("t4_dwait", {31'd0, dwait}, 0);
    chk("t4_dload", dload, 0);
    dWEN = 0; dREN = 0;
    tick();
    ramstate = RS_FREE; settle();

    // Test 5: ERROR twice then ACCESS during IGRANT
    iREN = 1; iaddr = 32'h90;
    tick();
    ramstate = RS_ERROR; settle();
    chk("t5_e1_ren", {31'd0, ramREN}, 1);
    chk("t5_e1_iwait", {31'd0, iwait}, 1);
    chk("t5_e1_err", {31'd0, ram_err}, 0);
    tick(); settle();
    chk("t5_e2_ren", {31'd0, ramREN}, 1);
    chk("t5_e2_addr", ramaddr, 32'h90);
    chk("t5_e2_err", {31'd0, ram_err}, 1);
    tick();
    ramstate = RS_ACCESS; ramload = 32'hCAFE_0001; settle();
    chk("t5_acc_iwait", {31'd0, iwait}, 0);
    chk("t5_acc_iload", iload, 32'hCAFE_0001);
    iREN = 0;
    tick();
    ramstate = RS_FREE; settle();
    chk("t5_after_err", {31'd0, ram_err}, 1);

    // Test 6a: dREN withdrawn mid-grant
    dREN = 1; daddr = 32'h400;
    tick();
    ramstate = RS_BUSY; settle();
    chk("t6_g_ren", {31'd0, ramREN}, 1);
    dREN = 0; settle();
    chk("t6_drop_ren", {31'd0, ramREN}, 0);
    chk("t6_drop_dwait", {31'd0, dwait}, 1);
    tick();
    dREN = 1; settle();
    chk("t6_idle_ren", {31'd0, ramREN}, 0);
    dREN = 0;

    // Test 6b: reset pulsed mid-grant
    tick();
    iREN = 1; iaddr = 32'hA0;
    tick(); settle();
    chk("t6_ig_ren", {31'd0, ramREN}, 1);
    chk("t6_ig_addr", ramaddr, 32'hA0);
    nRST = 0; settle();
    chk("t6_rst_ren", {31'd0, ramREN}, 0);
    chk("t6_rst_addr", ramaddr, 0);
    chk("t6_rst_iwait", {31'd0, iwait}, 1);
    chk("t6_rst_err", {31'd0, ram_err}, 0);
    tick();
    nRST = 1; iREN = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
